// File: rtl/seq_1011_frame_tx_if.sv
// Handshake and serial-line bundle between a frame source and seq_1011_frame_tx.
// The transmitter connects through the slave modport; the frame source uses master.
interface seq_1011_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              busy;
    logic              out;
    logic              frame_done;

    modport master (output start, data, input ready, busy, out, frame_done);
    modport slave  (input start, data, output ready, busy, out, frame_done);
endinterface

// File: rtl/seq_1011_frame_tx.sv
// Serial framer: 4-bit sync, then DATA_W payload bits MSB-first, then GAP idle-low cycles.
// The line, busy and frame_done outputs are registered; ready is decoded from the state.
module seq_1011_frame_tx #(
    parameter int         DATA_W = 8,
    parameter logic [3:0] SYNC   = 4'b1011,
    parameter int         GAP    = 2
) (
    input logic                clk,
    input logic                rst,
    seq_1011_frame_tx_if.slave bus
);
    localparam int MAXV = (DATA_W > 4) ? ((DATA_W > GAP + 1) ? DATA_W : GAP + 1)
                                       : ((GAP + 1 > 4) ? GAP + 1 : 4);
    localparam int CW   = $clog2(MAXV);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              out_q, out_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sh     <= '0;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sh     <= sh_n;
            out_q  <= out_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        out_n   = out_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                out_n  = 1'b0;
                busy_n = 1'b0;
                if (bus.start) begin
                    sh_n    = bus.data;
                    out_n   = SYNC[3];
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = S_SYNC;
                end
            end
            S_SYNC: begin
                // The line always carries the shift register MSB, so the first payload bit
                // comes out of the same shift path as the rest.
                if (cnt == CW'(3)) begin
                    out_n   = sh[DATA_W-1];
                    sh_n    = sh << 1;
                    cnt_n   = '0;
                    state_n = S_DATA;
                end else begin
                    out_n = SYNC[2'(2'd2 - cnt[1:0])];
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (int'(cnt) == DATA_W - 1) begin
                    out_n   = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    out_n = sh[DATA_W-1];
                    sh_n  = sh << 1;
                    cnt_n = cnt + CW'(1);
                end
            end
            S_GAP: begin
                out_n  = 1'b0;
                busy_n = 1'b0;
                if (int'(cnt) + 1 >= GAP) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.ready      = (state == S_IDLE);
    assign bus.busy       = busy_q;
    assign bus.out        = out_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_seq_1011_frame_tx.sv
// Bench for seq_1011_frame_tx: a phase-based frame model checks every cycle, plus directed
// frames, a loopback 1011 detector and a second DATA_W=1/GAP=0 instance.
module tb_seq_1011_frame_tx;
  localparam int         DW = 8;
  localparam int         GP = 2;
  localparam logic [3:0] SY = 4'b1011;
  localparam int         FL = 4 + DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_1011_frame_tx_if #(.DATA_W(DW)) bus ();
  seq_1011_frame_tx_if #(.DATA_W(1))  bus1 ();

  seq_1011_frame_tx #(.DATA_W(DW), .SYNC(SY), .GAP(GP)) dut (.clk(clk), .rst(rst), .bus(bus));
  seq_1011_frame_tx #(.DATA_W(1),  .SYNC(SY), .GAP(0))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: ph = edges since the accept edge (-1 when no frame has been accepted).
  int            ph = -1;
  logic [DW-1:0] word = '0;
  int            cyc = 0;
  int            acc_q[$];

  function automatic bit m_idle();
    return (ph < 0) || (ph >= FL + GP);
  endfunction

  function automatic logic exp_out();
    logic [3:0] s;
    s = SY;
    if (ph >= 0 && ph < 4) return s[3-ph];
    if (ph >= 4 && ph < FL) return word[DW-1-(ph-4)];
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) ph = -1;
    else begin
      cyc++;
      if (m_idle()) begin
        if (bus.start) begin
          ph   = 0;
          word = bus.data;
          acc_q.push_back(cyc);
        end else ph = -1;
      end else ph++;
    end
  end

  int         fd_cnt = 0;
  int         det_cnt = 0;
  int         det_ph[$];
  logic [3:0] hist = '0;

  always @(negedge clk) begin
    chk("out", bus.out, exp_out());
    chk("busy", bus.busy, (ph >= 0) && (ph < FL));
    chk("frame_done", bus.frame_done, ph == FL);
    chk("ready", bus.ready, m_idle());
    if (bus.frame_done) fd_cnt++;
    hist = {hist[2:0], bus.out};
    if (hist == 4'b1011) begin
      det_cnt++;
      det_ph.push_back(ph);
    end
  end

  task automatic send(input logic [DW-1:0] d);
    bus.start = 1'b1;
    bus.data  = d;
    @(negedge clk);
    bus.start = 1'b0;
    bus.data  = DW'($urandom);
  endtask

  logic [11:0] bits;
  logic [11:0] fds;

  initial begin
    bus.start  = 1'b0;
    bus.data   = '0;
    bus1.start = 1'b0;
    bus1.data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", bus.out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_ready", bus.ready, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single A5 frame against the literal expected stream
    send(8'hA5);
    for (int i = 0; i < 12; i++) begin
      bits = {bits[10:0], bus.out};
      @(negedge clk);
    end
    chk("a5_stream", bits, 12'hBA5);
    chk("a5_done", bus.frame_done, 1);
    chk("a5_out_low", bus.out, 0);
    @(negedge clk);
    chk("a5_ready_e13", bus.ready, 0);
    @(negedge clk);
    chk("a5_ready_e14", bus.ready, 1);
    repeat (3) @(negedge clk);

    // start/data pokes during a frame must not disturb it
    send(8'h5A);
    for (int i = 0; i < 12; i++) begin
      bits = {bits[10:0], bus.out};
      bus.start = (i == 2 || i == 7);
      bus.data  = 8'hFF;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("ign_stream", bits, 12'hB5A);
    repeat (4) @(negedge clk);

    // start held high: accepts exactly 15 edges apart, two frame_done pulses
    acc_q.delete();
    fd_cnt    = 0;
    bus.start = 1'b1;
    bus.data  = 8'h3C;
    @(negedge clk);
    bus.data = 8'hC3;
    repeat (29) @(negedge clk);
    bus.start = 1'b0;
    chk("held_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) chk("held_period", acc_q[1] - acc_q[0], 15);
    chk("held_done_cnt", fd_cnt, 2);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-payload
    send(8'hFF);
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_out", bus.out, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.frame_done, 0);
    chk("arst_ready", bus.ready, 1);
    fd_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_no_done", fd_cnt, 0);
    send(8'h96);
    repeat (16) @(negedge clk);
    chk("arst_resend_done", fd_cnt, 1);

    // Loopback through a 1011 detector
    det_cnt = 0;
    det_ph.delete();
    send(8'h00);
    repeat (16) @(negedge clk);
    chk("det00_cnt", det_cnt, 1);
    chk("det00_ph", (det_ph.size() > 0) ? det_ph[0] : -1, 3);
    det_cnt = 0;
    det_ph.delete();
    send(8'hB0);
    repeat (16) @(negedge clk);
    chk("detB0_cnt", det_cnt, 2);
    chk("detB0_ph", (det_ph.size() > 1) ? det_ph[1] : -1, 7);

    // DATA_W=1, GAP=0 instance with start held: re-accept at edge 6
    bus1.start = 1'b1;
    bus1.data  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      bits = {bits[10:0], bus1.out};
      fds  = {fds[10:0], bus1.frame_done};
      @(negedge clk);
    end
    bus1.start = 1'b0;
    chk("w1_stream", bits, 12'hBAE);
    chk("w1_done", fds, 12'h041);
    repeat (8) @(negedge clk);

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.data  = DW'($urandom);
      if ($urandom_range(0, 119) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
